// File: rtl/mem_access_stage.sv
// MEM stage with MEM/WB pipeline register: runs loads/stores against a multi-cycle data
// memory over a req/ack handshake, freezes upstream while pending, and aborts stuck accesses.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  RDaddr_o
);
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd_addr;
    } wb_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    wb_t           wb_q, wb_d;
    logic          access;
    logic          stall;
    logic          timeout_hit;

    assign access      = MemRead_i | MemWrite_i;
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CW'(TIMEOUT_CYC));

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wb_d    = wb_q;
        stall   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall   = 1'b1;
                    addr_d  = ALUResult_i;
                    wdata_d = WriteData_i;
                    we_d    = MemWrite_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    wb_d    = '0;
                    state_d = S_WAIT;
                end else begin
                    wb_d = '{RegWrite_i, MemtoReg_i, 32'd0, ALUResult_i, RDaddr_i};
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                wb_d  = '0;
                if (mem_ack_i) begin
                    rdata_d = we_q ? 32'd0 : mem_rdata_i;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        rdata_d = TIMEOUT_DATA;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // EX/MEM still holds the memory instruction; retire it and move on.
                wb_d    = '{RegWrite_i, MemtoReg_i, rdata_q, ALUResult_i, RDaddr_i};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
        end
    end

    // Stall is gated by reset so a held access cannot freeze the pipe while in reset.
    assign stall_o     = stall & rst_i;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign RegWrite_o  = wb_q.reg_write;
    assign MemtoReg_o  = wb_q.mem_to_reg;
    assign ReadData_o  = wb_q.read_data;
    assign ALUResult_o = wb_q.alu_result;
    assign RDaddr_o    = wb_q.rd_addr;

endmodule
